// File: rtl/hamming_frame_rx_if.sv
// Line-side input and codeword-side outputs of the serial Hamming frame receiver.
// master = receiver, slave = line driver / decoder side.
interface hamming_frame_rx_if #(
    parameter int DATA_W = 12
) ();
    logic              rx;
    logic [DATA_W-1:0] hc_out;
    logic              rden;
    logic              frame_err;
    logic              busy;

    modport master (
        input  rx,
        output hc_out,
        output rden,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  hc_out,
        input  rden,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/hamming_frame_rx.sv
// Oversampling serial receiver: start + DATA_W codeword bits (LSB first) + stop.
// Good frames load hc_out with a 1-cycle rden strobe; bad stop bits pulse frame_err.
module hamming_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    hamming_frame_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] hc_q, hc_d;
    logic              rden_q, rden_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        hc_d      = hc_q;
        rden_d    = 1'b0;
        ferr_d    = 1'b0;
        sync1_d   = bus.rx;
        sync2_d   = sync1_q;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    sh_d[bit_idx_q]    = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        hc_d   = sh_q;
                        rden_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Synchroniser resets to 1 so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            hc_q      <= '0;
            rden_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            hc_q      <= hc_d;
            rden_q    <= rden_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign bus.hc_out    = hc_q;
    assign bus.rden      = rden_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
endmodule
